alu_wb_buffer: RTL and testbench

- Consumer end of the MicroUAZ ALU result path: takes N-bit results from the logic/arith operators (AND/OR/XOR/...) with a valid/ready handshake.
- Buffers results in a 2-entry FIFO and writes them to the register file write port, honouring a register-file stall.
- Maintains the Z/N/P status flags register updated on retirement.
- Sits between the ALU output mux and the register file.

---
 rtl/alu_wb_buffer.sv | 85 ++++++++
 tb/tb_alu_wb_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// Write-back buffer between the ALU result mux and the register file.
// Holds up to two results in FIFO order and keeps the Z/N/P status flags.
module alu_wb_buffer #(
    parameter int N  = 8,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [RA-1:0] in_rd,
    input  logic          in_upd_flags,
    output logic          rf_we,
    output logic [RA-1:0] rf_waddr,
    output logic [N-1:0]  rf_wdata,
    input  logic          rf_stall,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_p,
    output logic [1:0]    count
);

    logic [N-1:0]  data_q [2];
    logic [RA-1:0] rd_q   [2];
    logic [1:0]    upd_q;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          accept;
    logic          retire;

    function automatic logic zero_of(input logic [N-1:0] d);
        return ~|d;
    endfunction

    function automatic logic parity_even_of(input logic [N-1:0] d);
        return ~^d;
    endfunction

    // in_ready looks only at registered occupancy, so a retire at count=2
    // frees the slot for the following cycle rather than this one.
    assign in_ready = (count != 2'd2);
    assign rf_we    = (count != 2'd0);
    assign rf_waddr = rd_q[rd_ptr];
    assign rf_wdata = data_q[rd_ptr];
    assign accept   = in_valid && in_ready;
    assign retire   = rf_we && !rf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
            upd_q  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            flag_z <= 1'b1;
            flag_n <= 1'b0;
            flag_p <= 1'b1;
        end else begin
            if (accept) begin
                data_q[wr_ptr] <= in_data;
                rd_q[wr_ptr]   <= in_rd;
                upd_q[wr_ptr]  <= in_upd_flags;
                wr_ptr         <= ~wr_ptr;
            end
            if (retire) begin
                rd_ptr <= ~rd_ptr;
                if (upd_q[rd_ptr]) begin
                    flag_z <= zero_of(data_q[rd_ptr]);
                    flag_n <= data_q[rd_ptr][N-1];
                    flag_p <= parity_even_of(data_q[rd_ptr]);
                end
            end
            case ({accept, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer: reset, single/back-to-back transfers,
// stall back-pressure, flag selection and asynchronous reset under stall.
module tb_alu_wb_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_rd;
    logic       in_upd_flags;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       rf_stall;
    logic       flag_z;
    logic       flag_n;
    logic       flag_p;
    logic [1:0] count;

    int passed = 0;
    int total  = 0;

    alu_wb_buffer #(.N(8), .RA(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_rd(in_rd),
        .in_upd_flags(in_upd_flags),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .rf_stall(rf_stall),
        .flag_z(flag_z),
        .flag_n(flag_n),
        .flag_p(flag_p),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] r, input logic u);
        in_valid     = v;
        in_data      = d;
        in_rd        = r;
        in_upd_flags = u;
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic n, input logic p);
        chk({tag, "_z"}, {31'd0, flag_z}, {31'd0, z});
        chk({tag, "_n"}, {31'd0, flag_n}, {31'd0, n});
        chk({tag, "_p"}, {31'd0, flag_p}, {31'd0, p});
    endtask

    logic [7:0] vec [4];

    initial begin
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'hxx;
        in_rd        = 3'bxxx;
        in_upd_flags = 1'b0;
        rf_stall     = 1'b0;
        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        // reset then idle, with X on data lines
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_count", {30'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_waddr", {29'd0, rf_waddr}, 32'd0);
        chk("rst_wdata", {24'd0, rf_wdata}, 32'd0);
        chk_flags("rst", 1'b1, 1'b0, 1'b1);

        // single transfer
        drive(1'b1, 8'hA5, 3'd3, 1'b1);
        chk("single_no_writethrough", {31'd0, rf_we}, 32'd0);
        step();
        drive(1'b0, 8'hxx, 3'bxxx, 1'b0);
        chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_waddr", {29'd0, rf_waddr}, 32'd3);
        chk("single_wdata", {24'd0, rf_wdata}, 32'hA5);
        chk("single_count1", {30'd0, count}, 32'd1);
        chk_flags("single_pre", 1'b1, 1'b0, 1'b1);
        step();
        chk("single_count0", {30'd0, count}, 32'd0);
        chk("single_we_off", {31'd0, rf_we}, 32'd0);
        chk_flags("single_post", 1'b0, 1'b1, 1'b1);

        // back-to-back, no stall
        vec[0] = 8'h01; vec[1] = 8'h00; vec[2] = 8'hF0; vec[3] = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vec[i], 3'(i + 1), 1'b1);
            chk("b2b_ready", {31'd0, in_ready}, 32'd1);
            step();
            chk("b2b_we", {31'd0, rf_we}, 32'd1);
            chk("b2b_wdata", {24'd0, rf_wdata}, {24'd0, vec[i]});
            chk("b2b_waddr", {29'd0, rf_waddr}, 32'(i + 1));
            chk("b2b_count", {30'd0, count}, 32'd1);
        end
        drive(1'b0, 8'hxx, 3'bxxx, 1'b0);
        chk("b2b_ready_end", {31'd0, in_ready}, 32'd1);
        step();
        chk("b2b_count0", {30'd0, count}, 32'd0);
        chk_flags("b2b", 1'b0, 1'b0, 1'b1);

        // stall for 5 cycles with three results offered
        rf_stall = 1'b1;
        drive(1'b1, 8'h11, 3'd5, 1'b0);
        step();
        chk("stall_count1", {30'd0, count}, 32'd1);
        chk("stall_wdata1", {24'd0, rf_wdata}, 32'h11);
        drive(1'b1, 8'h22, 3'd6, 1'b0);
        step();
        chk("stall_count2", {30'd0, count}, 32'd2);
        chk("stall_ready0", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 8'h33, 3'd7, 1'b0);
        step();
        step();
        step();
        chk("stall_hold_count", {30'd0, count}, 32'd2);
        chk("stall_hold_we", {31'd0, rf_we}, 32'd1);
        chk("stall_hold_wdata", {24'd0, rf_wdata}, 32'h11);
        chk("stall_hold_waddr", {29'd0, rf_waddr}, 32'd5);
        rf_stall = 1'b0;
        step();
        chk("rel_count_a", {30'd0, count}, 32'd1);
        chk("rel_wdata_22", {24'd0, rf_wdata}, 32'h22);
        chk("rel_ready1", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b0, 8'hxx, 3'bxxx, 1'b0);
        chk("rel_count_b", {30'd0, count}, 32'd1);
        chk("rel_wdata_33", {24'd0, rf_wdata}, 32'h33);
        chk("rel_waddr_7", {29'd0, rf_waddr}, 32'd7);
        step();
        chk("rel_count0", {30'd0, count}, 32'd0);
        chk_flags("rel_noupd", 1'b0, 1'b0, 1'b1);

        // flag select: only the first result updates flags
        drive(1'b1, 8'h00, 3'd0, 1'b1);
        step();
        drive(1'b1, 8'h80, 3'd1, 1'b0);
        chk("fsel_wdata00", {24'd0, rf_wdata}, 32'h00);
        step();
        drive(1'b0, 8'hxx, 3'bxxx, 1'b0);
        chk("fsel_wdata80", {24'd0, rf_wdata}, 32'h80);
        chk("fsel_waddr1", {29'd0, rf_waddr}, 32'd1);
        step();
        chk("fsel_count0", {30'd0, count}, 32'd0);
        chk_flags("fsel", 1'b1, 1'b0, 1'b1);

        // move flags away from reset values, then reset with count=2 under stall
        drive(1'b1, 8'h7F, 3'd4, 1'b1);
        step();
        drive(1'b0, 8'hxx, 3'bxxx, 1'b0);
        step();
        chk_flags("pre_rst", 1'b0, 1'b0, 1'b0);
        rf_stall = 1'b1;
        drive(1'b1, 8'hAA, 3'd2, 1'b1);
        step();
        drive(1'b1, 8'hBB, 3'd3, 1'b1);
        step();
        drive(1'b0, 8'hxx, 3'bxxx, 1'b0);
        chk("mid_count2", {30'd0, count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
        chk("mid_rst_count", {30'd0, count}, 32'd0);
        chk_flags("mid_rst", 1'b1, 1'b0, 1'b1);
        step();
        rst_n    = 1'b1;
        rf_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_we", {31'd0, rf_we}, 32'd0);
            chk("post_rst_count", {30'd0, count}, 32'd0);
        end
        chk_flags("post_rst", 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
